// File: rtl/vdc_cpu_port.sv
// HuC6270 VDC CPU register port: AR decode, 16-bit register assembly,
// MAWR/MARR/VRR ownership and auto-incrementing VRAM requests to the arbiter.
`timescale 1ns/1ps
module vdc_cpu_port #(
    parameter int unsigned VRAM_AW = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cs_n,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic [1:0]         a,
    input  logic [7:0]         d_in,
    output logic [7:0]         d_out,
    output logic               busy_n,
    input  logic [5:0]         status_in,
    output logic               status_rd,
    output logic               reg_wr,
    output logic [4:0]         reg_sel,
    output logic [15:0]        reg_data,
    output logic [1:0]         cr_inc,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [15:0]        vram_wdata,
    input  logic               vram_ack,
    input  logic [15:0]        vram_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    state_t               state_q;
    logic [4:0]           ar_q;
    logic [7:0]           data_lo_q;
    logic [VRAM_AW-1:0]   mawr_q;
    logic [VRAM_AW-1:0]   marr_q;
    logic [15:0]          vrr_q;
    logic [1:0]           cr_inc_q;
    logic                 wr_act_q;
    logic                 rd_act_q;
    logic [7:0]           d_out_q;
    logic                 status_rd_q;
    logic                 reg_wr_q;
    logic [4:0]           reg_sel_q;
    logic [15:0]          reg_data_q;
    logic                 vram_req_q;
    logic                 vram_we_q;
    logic [VRAM_AW-1:0]   vram_addr_q;
    logic [15:0]          vram_wdata_q;

    logic                 wr_act;
    logic                 rd_act;
    logic                 wr_ev;
    logic                 rd_ev;
    logic [15:0]          word;
    logic [VRAM_AW-1:0]   inc;
    logic [VRAM_AW-1:0]   marr_step;
    logic                 commit;
    logic                 vrr_hi_rd;
    logic                 trig_rd;
    logic                 trig_wr;
    logic [VRAM_AW-1:0]   rd_addr;
    logic                 idle;

    // Edge-detected strobes; a simultaneous write suppresses the read.
    assign wr_act = !cs_n && !wr_n;
    assign rd_act = !cs_n && !rd_n;
    assign wr_ev  = wr_act && !wr_act_q;
    assign rd_ev  = rd_act && !rd_act_q && !wr_act;

    assign word      = {d_in, data_lo_q};
    assign commit    = wr_ev && (a == 2'd3);
    assign vrr_hi_rd = rd_ev && (a == 2'd3);
    assign marr_step = marr_q + inc;
    assign trig_rd   = (commit && (ar_q == 5'h01)) || (vrr_hi_rd && (ar_q == 5'h02));
    assign trig_wr   = commit && (ar_q == 5'h02);
    assign rd_addr   = commit ? VRAM_AW'(word) : marr_step;
    assign idle      = (state_q == ST_IDLE);

    always_comb begin
        case (cr_inc_q)
            2'd0: inc = VRAM_AW'(1);
            2'd1: inc = VRAM_AW'(32);
            2'd2: inc = VRAM_AW'(64);
            2'd3: inc = VRAM_AW'(128);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ar_q         <= 5'd0;
            data_lo_q    <= 8'd0;
            mawr_q       <= '0;
            marr_q       <= '0;
            vrr_q        <= 16'd0;
            cr_inc_q     <= 2'd0;
            wr_act_q     <= 1'b0;
            rd_act_q     <= 1'b0;
            d_out_q      <= 8'd0;
            status_rd_q  <= 1'b0;
            reg_wr_q     <= 1'b0;
            reg_sel_q    <= 5'd0;
            reg_data_q   <= 16'd0;
            vram_req_q   <= 1'b0;
            vram_we_q    <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= 16'd0;
        end else begin
            wr_act_q    <= wr_act;
            rd_act_q    <= rd_act;
            reg_wr_q    <= 1'b0;
            status_rd_q <= 1'b0;

            // Outstanding VRAM operation completes on ack.
            case (state_q)
                ST_WR: if (vram_ack) begin
                    mawr_q     <= mawr_q + inc;
                    vram_req_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                ST_RD: if (vram_ack) begin
                    vrr_q      <= vram_rdata;
                    vram_req_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: ;
            endcase

            // Triggers while busy are dropped; the CPU polls busy_n.
            if (idle && (trig_rd || trig_wr)) begin
                state_q     <= trig_wr ? ST_WR : ST_RD;
                vram_req_q  <= 1'b1;
                vram_we_q   <= trig_wr;
                vram_addr_q <= trig_wr ? mawr_q : rd_addr;
                if (trig_wr)
                    vram_wdata_q <= word;
            end

            if (wr_ev) begin
                case (a)
                    2'd0: ar_q      <= d_in[4:0];
                    2'd2: data_lo_q <= d_in;
                    2'd3: begin
                        if (ar_q == 5'h00)
                            mawr_q <= VRAM_AW'(word);
                        if (ar_q == 5'h01)
                            marr_q <= VRAM_AW'(word);
                        if (ar_q == 5'h05)
                            cr_inc_q <= word[12:11];
                        if (ar_q >= 5'h05 && ar_q <= 5'h13) begin
                            reg_wr_q   <= 1'b1;
                            reg_sel_q  <= ar_q;
                            reg_data_q <= word;
                        end
                    end
                    default: ;
                endcase
            end else if (rd_ev) begin
                case (a)
                    2'd0: begin
                        d_out_q     <= {1'b0, !idle, status_in};
                        status_rd_q <= 1'b1;
                    end
                    2'd1: d_out_q <= 8'h00;
                    2'd2: d_out_q <= vrr_q[7:0];
                    2'd3: begin
                        d_out_q <= vrr_q[15:8];
                        if (ar_q == 5'h02)
                            marr_q <= marr_step;
                    end
                endcase
            end
        end
    end

    assign d_out      = d_out_q;
    assign busy_n     = idle;
    assign status_rd  = status_rd_q;
    assign reg_wr     = reg_wr_q;
    assign reg_sel    = reg_sel_q;
    assign reg_data   = reg_data_q;
    assign cr_inc     = cr_inc_q;
    assign vram_req   = vram_req_q;
    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vdc_cpu_port.sv
// Directed bench for vdc_cpu_port: CPU register writes/reads against a
// hand-driven VRAM arbiter, with hand-computed expectations.
`timescale 1ns/1ps
module tb_vdc_cpu_port;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cs_n, wr_n, rd_n;
    logic [1:0]  a;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        busy_n;
    logic [5:0]  status_in;
    logic        status_rd;
    logic        reg_wr;
    logic [4:0]  reg_sel;
    logic [15:0] reg_data;
    logic [1:0]  cr_inc;
    logic        vram_req, vram_we;
    logic [15:0] vram_addr, vram_wdata;
    logic        vram_ack;
    logic [15:0] vram_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    vdc_cpu_port #(.VRAM_AW(16)) dut (
        .clock(clock), .reset_n(reset_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .a(a), .d_in(d_in), .d_out(d_out), .busy_n(busy_n),
        .status_in(status_in), .status_rd(status_rd),
        .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_data(reg_data), .cr_inc(cr_inc),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
        @(negedge clock);
        cs_n = 1'b0; wr_n = 1'b0; a = addr; d_in = data;
        @(negedge clock);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] addr, output logic [7:0] data, output logic srd);
        @(negedge clock);
        cs_n = 1'b0; rd_n = 1'b0; a = addr;
        @(negedge clock);
        cs_n = 1'b1; rd_n = 1'b1;
        data = d_out;
        srd  = status_rd;
    endtask

    task automatic arb_ack(input logic [15:0] rdata);
        @(negedge clock);
        vram_ack = 1'b1; vram_rdata = rdata;
        @(negedge clock);
        vram_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       srd;
        int         pulses;

        reset_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        a = 2'd0; d_in = 8'h00; vram_ack = 1'b0; vram_rdata = 16'h0000;
        status_in = 6'h15;
        repeat (2) @(negedge clock);
        check("rst_d_out", 32'(d_out), 32'h00);
        check("rst_busy_n", 32'(busy_n), 32'd1);
        check("rst_vram_req", 32'(vram_req), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_reg_data", 32'(reg_data), 32'd0);
        check("rst_cr_inc", 32'(cr_inc), 32'd0);
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        check("rst_status_rd", 32'(status_rd), 32'd0);
        reset_n = 1'b1;

        // VWR write at MAWR=0x1234
        cpu_write(2'd0, 8'h00); cpu_write(2'd2, 8'h34); cpu_write(2'd3, 8'h12);
        cpu_write(2'd0, 8'h02); cpu_write(2'd2, 8'hCD); cpu_write(2'd3, 8'hAB);
        check("wr1_req", 32'(vram_req), 32'd1);
        check("wr1_we", 32'(vram_we), 32'd1);
        check("wr1_addr", 32'(vram_addr), 32'h1234);
        check("wr1_wdata", 32'(vram_wdata), 32'hABCD);
        check("wr1_busy_n", 32'(busy_n), 32'd0);
        repeat (2) @(negedge clock);
        check("wr1_hold_req", 32'(vram_req), 32'd1);
        check("wr1_hold_addr", 32'(vram_addr), 32'h1234);
        arb_ack(16'h0000);
        check("wr1_done_req", 32'(vram_req), 32'd0);
        check("wr1_done_busy_n", 32'(busy_n), 32'd1);
        cpu_write(2'd2, 8'h11); cpu_write(2'd3, 8'h22);
        check("wr2_addr_mawr_inc", 32'(vram_addr), 32'h1235);
        check("wr2_wdata", 32'(vram_wdata), 32'h2211);
        arb_ack(16'h0000);

        // CR inc=128 and MAWR wrap from 0xFFC0
        cpu_write(2'd0, 8'h05); cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h18);
        check("cr_reg_wr", 32'(reg_wr), 32'd1);
        check("cr_reg_sel", 32'(reg_sel), 32'h05);
        check("cr_reg_data", 32'(reg_data), 32'h1800);
        check("cr_inc", 32'(cr_inc), 32'd3);
        @(negedge clock);
        check("cr_reg_wr_pulse_end", 32'(reg_wr), 32'd0);
        cpu_write(2'd0, 8'h00); cpu_write(2'd2, 8'hC0); cpu_write(2'd3, 8'hFF);
        cpu_write(2'd0, 8'h02); cpu_write(2'd2, 8'h78); cpu_write(2'd3, 8'h56);
        check("wr3_addr", 32'(vram_addr), 32'hFFC0);
        check("wr3_wdata", 32'(vram_wdata), 32'h5678);
        arb_ack(16'h0000);
        cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h00);
        check("wr4_addr_wrap", 32'(vram_addr), 32'h0040);
        arb_ack(16'h0000);
        cpu_write(2'd0, 8'h05); cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h00);
        check("cr_inc_back_1", 32'(cr_inc), 32'd0);

        // MARR load triggers read; arbiter answers 3 cycles later
        cpu_write(2'd0, 8'h01); cpu_write(2'd2, 8'h00); cpu_write(2'd3, 8'h01);
        check("rd1_req", 32'(vram_req), 32'd1);
        check("rd1_we", 32'(vram_we), 32'd0);
        check("rd1_addr", 32'(vram_addr), 32'h0100);
        repeat (2) @(negedge clock);
        arb_ack(16'h5AA5);
        check("rd1_done_req", 32'(vram_req), 32'd0);
        cpu_write(2'd0, 8'h02);
        cpu_read(2'd2, rd, srd);
        check("vrr_lo", 32'(rd), 32'hA5);
        cpu_read(2'd3, rd, srd);
        check("vrr_hi", 32'(rd), 32'h5A);
        check("rd2_req", 32'(vram_req), 32'd1);
        check("rd2_addr", 32'(vram_addr), 32'h0101);
        check("rd2_we", 32'(vram_we), 32'd0);

        // Busy: status bit6, dropped VWR write
        cpu_read(2'd0, rd, srd);
        check("status_busy", 32'(rd), 32'h55);
        check("status_rd_pulse", 32'(srd), 32'd1);
        @(negedge clock);
        check("status_rd_end", 32'(status_rd), 32'd0);
        cpu_write(2'd2, 8'hEE); cpu_write(2'd3, 8'hDD);
        check("drop_we", 32'(vram_we), 32'd0);
        check("drop_addr", 32'(vram_addr), 32'h0101);
        arb_ack(16'h1357);
        check("drop_req_low", 32'(vram_req), 32'd0);
        @(negedge clock);
        check("drop_no_extra_req", 32'(vram_req), 32'd0);
        cpu_read(2'd0, rd, srd);
        check("status_idle", 32'(rd), 32'h15);
        cpu_read(2'd1, rd, srd);
        check("read_a1", 32'(rd), 32'h00);
        cpu_read(2'd2, rd, srd);
        check("vrr2_lo", 32'(rd), 32'h57);

        // Non-local register write, held strobe, ignored register
        cpu_write(2'd0, 8'h0A); cpu_write(2'd2, 8'h02); cpu_write(2'd3, 8'h0F);
        check("r0a_reg_wr", 32'(reg_wr), 32'd1);
        check("r0a_reg_sel", 32'(reg_sel), 32'h0A);
        check("r0a_reg_data", 32'(reg_data), 32'h0F02);
        @(negedge clock);
        check("r0a_pulse_end", 32'(reg_wr), 32'd0);
        pulses = 0;
        cs_n = 1'b0; wr_n = 1'b0; a = 2'd3; d_in = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (reg_wr) pulses++;
        end
        cs_n = 1'b1; wr_n = 1'b1;
        @(negedge clock);
        if (reg_wr) pulses++;
        check("held_wr_one_pulse", 32'(pulses), 32'd1);
        cpu_write(2'd0, 8'h14); cpu_write(2'd2, 8'h01); cpu_write(2'd3, 8'h02);
        check("r14_no_pulse", 32'(reg_wr), 32'd0);
        check("r14_no_req", 32'(vram_req), 32'd0);

        // MARR wrap 0xFFFF + 1
        cpu_write(2'd0, 8'h01); cpu_write(2'd2, 8'hFF); cpu_write(2'd3, 8'hFF);
        check("rd3_addr", 32'(vram_addr), 32'hFFFF);
        arb_ack(16'hBEEF);
        cpu_write(2'd0, 8'h02);
        cpu_read(2'd3, rd, srd);
        check("rd3_vrr_hi", 32'(rd), 32'hBE);
        check("rd4_addr_wrap", 32'(vram_addr), 32'h0000);
        check("rd4_req", 32'(vram_req), 32'd1);
        arb_ack(16'h0000);

        // Reset during an outstanding write
        cpu_write(2'd2, 8'h01); cpu_write(2'd3, 8'h01);
        check("wr5_req", 32'(vram_req), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_mid_req", 32'(vram_req), 32'd0);
        check("rst_mid_busy_n", 32'(busy_n), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        cpu_write(2'd0, 8'h02); cpu_write(2'd2, 8'h44); cpu_write(2'd3, 8'h33);
        check("post_rst_req", 32'(vram_req), 32'd1);
        check("post_rst_mawr0", 32'(vram_addr), 32'h0000);
        check("post_rst_wdata", 32'(vram_wdata), 32'h3344);
        arb_ack(16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vdc_cpu_port.md
Name: vdc_cpu_port

Overview:
- CPU-facing register port of the HuC6270 VDC model: the responder to HuC6280 bus accesses (CS_n/WR_n/RD_n, A[1:0], 8-bit data).
- Decodes the address register (AR), assembles 16-bit register writes, and owns MAWR, MARR, VWR, VRR and CR increment bits.
- Issues VRAM read/write requests with auto-increment to the VRAM arbiter.
- Forwards all other register writes to the display/sprite units.

Parameters:
- VRAM_AW, 16, VRAM word-address width; MAWR/MARR wrap modulo 2^VRAM_AW.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cs_n  in  1  chip select, synchronous to clock
- wr_n  in  1  write strobe, active-low
- rd_n  in  1  read strobe, active-low
- a  in  2  CPU register address
- d_in  in  8  CPU write data
- d_out  out  8  CPU read data
- busy_n  out  1  low while a VRAM operation is outstanding
- status_in  in  6  status bits [5:0] from the IRQ/timing logic
- status_rd  out  1  one-cycle pulse when the status register is read
- reg_wr  out  1  one-cycle pulse: write to a non-local register
- reg_sel  out  5  register index for reg_wr
- reg_data  out  16  data for reg_wr
- cr_inc  out  2  CR[12:11] increment select
- vram_req  out  1  VRAM request, held until ack
- vram_we  out  1  1 = write, 0 = read
- vram_addr  out  VRAM_AW  VRAM word address
- vram_wdata  out  16  write data
- vram_ack  in  1  one-cycle completion from the arbiter
- vram_rdata  in  16  read data, valid when vram_ack=1

Behaviour:
- Reset (async, reset_n=0): AR=0, MAWR=0, MARR=0, VRR=0, data_lo=0, cr_inc=0, FSM=IDLE. Outputs: d_out=0, busy_n=1, status_rd=0, reg_wr=0, reg_sel=0, reg_data=0, vram_req=0, vram_we=0, vram_addr=0, vram_wdata=0.
- Access events:
  - Write event: the first cycle with cs_n=0 and wr_n=0, when the previous cycle did not satisfy that condition.
  - Read event: same rule using rd_n.
  - Held strobes produce exactly one event. If wr_n and rd_n are both low, the write wins and the read is ignored.
- Increment inc = 1/32/64/128 for cr_inc = 0/1/2/3.
- Writes:
  - a=0: AR <= d_in[4:0].
  - a=1: ignored.
  - a=2: data_lo <= d_in.
  - a=3: commits word W = {d_in, data_lo} to the register selected by AR:
    - AR=0x00: MAWR <= W.
    - AR=0x01: MARR <= W; triggers a VRAM read at W.
    - AR=0x02: triggers a VRAM write of W at MAWR.
    - AR=0x05: cr_inc <= W[12:11]; also reg_wr pulse with reg_sel=5, reg_data=W.
    - AR in 0x06..0x13: reg_wr pulse the cycle after the event, with reg_sel=AR, reg_data=W.
    - AR in 0x03, 0x04, 0x14..0x1F: ignored.
- Reads: d_out is registered and updated the cycle after the read event; it holds its value otherwise.
  - a=0: {1'b0, ~busy_n, status_in}; status_rd pulses for one cycle.
  - a=1: 0x00.
  - a=2: VRR[7:0].
  - a=3: VRR[15:8]. If AR=0x02, MARR <= MARR+inc and a VRAM read is triggered at the new MARR.
- VRAM FSM (states IDLE, WR, RD):
  - A trigger in IDLE moves to WR/RD on the next edge; vram_req=1 with vram_addr/vram_we/vram_wdata stable from that cycle until the vram_ack cycle inclusive.
  - WR + ack: MAWR <= MAWR+inc, return to IDLE, vram_req=0 the next cycle.
  - RD + ack: VRR <= vram_rdata, return to IDLE.
  - busy_n = (state==IDLE).
  - vram_ack while IDLE is ignored.
- Trigger while not IDLE: the VRAM operation is dropped. Register side effects still apply: MARR is loaded (AR=1 write) or incremented (VRR high read). The CPU is required to poll busy_n.
- MAWR/MARR arithmetic wraps: 0xFFFF + 1 = 0x0000; 0xFFF0 + 32 = 0x0010.
- reset_n asserted mid-operation: vram_req drops immediately; the pending operation is abandoned.

Test Plan:
- Write AR=0, data 0x34, 0x12; AR=2, data 0xCD, 0xAB -> vram_req with we=1, addr=0x1234, wdata=0xABCD until ack; afterwards MAWR=0x1235 and busy_n=1.
- Write CR via AR=5 with W=0x1800 (inc=128), MAWR=0xFFC0, then a VWR write -> reg_wr pulse sel=5 data=0x1800; VRAM write at 0xFFC0; MAWR becomes 0x0040 (wrap).
- AR=1 with W=0x0100; arbiter returns 0x5AA5 after 3 cycles -> read req addr=0x0100; VRR=0x5AA5. Then AR=2, read a=2 gives 0xA5; read a=3 gives 0x5A and a new read issues at 0x0101.
- Issue a VWR write while the RD state awaits ack -> second operation dropped, no extra vram_req; a status read shows bit6=1, then 0 after ack.
- Write AR=0x0A data 0x0F02 -> exactly one reg_wr cycle with sel=0x0A, data=0x0F02. Hold wr_n low 5 cycles -> still one pulse. AR=0x14 -> no pulse.
- Pull reset_n low during an outstanding write -> vram_req=0 and busy_n=1 immediately; MAWR=0 after release.
